// File: rtl/priority_encoder.sv
// rtl/priority_encoder.sv - registered priority encoder with one-hot and multi-request flags
//
// Parameters
//   WIDTH        number of request bits (>= 2, any value)
//   LSB_PRIORITY 0: highest set index wins, 1: lowest set index wins
//
// Ports
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset, clears all outputs
//   en      1: capture D on this edge, 0: hold outputs
//   D       request vector
//   ENC     registered index of the winning request
//   VLD     registered OR of the captured request vector
//   ONEHOT  registered one-hot mask of the winner, zero when no request
//   MULTI   registered flag, two or more requests were set

module priority_encoder #(
  parameter int WIDTH        = 4,
  parameter int LSB_PRIORITY = 0,
  parameter int EW           = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] D,
  output logic [EW-1:0]    ENC,
  output logic             VLD,
  output logic [WIDTH-1:0] ONEHOT,
  output logic             MULTI
);

  logic [EW-1:0]    enc_next;
  logic [WIDTH-1:0] onehot_next;
  logic             vld_next;
  logic             multi_next;
  logic             found;

  // Position visited at step i of the scan: the scan always starts at the
  // top-priority end so the first set bit met is the winner.
  function automatic int scan_idx(input int i);
    return (LSB_PRIORITY != 0) ? i : (WIDTH - 1 - i);
  endfunction

  // Any set bit met after the winner can only raise MULTI; it never touches
  // ENC or ONEHOT, which keeps lower-priority bits out of the result.
  always_comb begin
    enc_next    = '0;
    onehot_next = '0;
    found       = 1'b0;
    multi_next  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (D[scan_idx(i)]) begin
        if (found) begin
          multi_next = 1'b1;
        end else begin
          found                    = 1'b1;
          enc_next                 = EW'(scan_idx(i));
          onehot_next[scan_idx(i)] = 1'b1;
        end
      end
    end
    vld_next = found;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ENC    <= '0;
      VLD    <= 1'b0;
      ONEHOT <= '0;
      MULTI  <= 1'b0;
    end else if (en) begin
      ENC    <= enc_next;
      VLD    <= vld_next;
      ONEHOT <= onehot_next;
      MULTI  <= multi_next;
    end
  end

endmodule

// File: tb/tb_priority_encoder.sv
// tb/tb_priority_encoder.sv - self-checking bench for priority_encoder
module tb_priority_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [4:0] d5;
  logic [3:0] d4;

  logic [1:0] enc_m4, enc_l4;
  logic [2:0] enc_m5;
  logic       vld_m4, vld_l4, vld_m5;
  logic [3:0] oh_m4, oh_l4;
  logic [4:0] oh_m5;
  logic       multi_m4, multi_l4, multi_m5;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  int   exp_enc[3];
  bit   exp_vld[3];
  int   exp_oh[3];
  bit   exp_multi[3];

  assign d4 = d5[3:0];

  always #5 clk = ~clk;

  priority_encoder #(.WIDTH(4), .LSB_PRIORITY(0)) u_m4 (
    .clk(clk), .rst_n(rst_n), .en(en), .D(d4),
    .ENC(enc_m4), .VLD(vld_m4), .ONEHOT(oh_m4), .MULTI(multi_m4));

  priority_encoder #(.WIDTH(4), .LSB_PRIORITY(1)) u_l4 (
    .clk(clk), .rst_n(rst_n), .en(en), .D(d4),
    .ENC(enc_l4), .VLD(vld_l4), .ONEHOT(oh_l4), .MULTI(multi_l4));

  priority_encoder #(.WIDTH(5), .LSB_PRIORITY(0)) u_m5 (
    .clk(clk), .rst_n(rst_n), .en(en), .D(d5),
    .ENC(enc_m5), .VLD(vld_m5), .ONEHOT(oh_m5), .MULTI(multi_m5));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: winner by arithmetic (floor log2 / isolate lowest set bit).
  function automatic void model(input bit lsb, input int d,
                                output int enc, output bit vld,
                                output int oh, output bit multi);
    vld   = (d != 0);
    multi = ($countones(d) > 1);
    enc   = 0;
    oh    = 0;
    if (vld) begin
      if (lsb) begin
        oh  = d & (-d);
        enc = $clog2(oh);
      end else begin
        enc = $clog2(d + 1) - 1;
        oh  = 1 << enc;
      end
    end
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        exp_enc[k] = 0; exp_vld[k] = 0; exp_oh[k] = 0; exp_multi[k] = 0;
      end else if (en) begin
        model(k == 1, (k == 2) ? int'(d5) : int'(d4),
              exp_enc[k], exp_vld[k], exp_oh[k], exp_multi[k]);
      end
    end
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m4_enc", enc_m4, exp_enc[0]);
      chk("m4_vld", vld_m4, exp_vld[0]);
      chk("m4_oh", oh_m4, exp_oh[0]);
      chk("m4_multi", multi_m4, exp_multi[0]);
      chk("l4_enc", enc_l4, exp_enc[1]);
      chk("l4_vld", vld_l4, exp_vld[1]);
      chk("l4_oh", oh_l4, exp_oh[1]);
      chk("l4_multi", multi_l4, exp_multi[1]);
      chk("m5_enc", enc_m5, exp_enc[2]);
      chk("m5_vld", vld_m5, exp_vld[2]);
      chk("m5_oh", oh_m5, exp_oh[2]);
      chk("m5_multi", multi_m5, exp_multi[2]);
    end
  end

  // Drive at negedge, let one rising edge pass, land on the next negedge.
  task automatic step(input bit r, input bit e, input logic [4:0] d);
    @(negedge clk);
    rst_n = r; en = e; d5 = d;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] multi_set;
    int          sweep_enc;
    multi_set = 16'hFEE8;
    rst_n = 1'b0; en = 1'b1; d5 = 5'(($urandom));

    step(0, 1, 5'b11111);
    step(0, 0, 5'b10101);
    chk("rst_enc", enc_m4, 0);
    chk("rst_vld", vld_m4, 0);
    chk("rst_oh", oh_m4, 0);
    chk("rst_multi", multi_m4, 0);

    for (int d = 0; d < 16; d++) begin
      step(1, 1, 5'(d));
      sweep_enc = (d < 2) ? 0 : (d < 4) ? 1 : (d < 8) ? 2 : 3;
      chk("sweep_enc", enc_m4, sweep_enc);
      chk("sweep_vld", vld_m4, (d > 0) ? 1 : 0);
      chk("sweep_multi", multi_m4, int'(multi_set[d]));
    end

    step(1, 1, 5'b00110);
    chk("m4_0110_enc", enc_m4, 2);
    chk("m4_0110_vld", vld_m4, 1);
    chk("m4_0110_oh", oh_m4, 4);
    chk("m4_0110_multi", multi_m4, 1);
    chk("l4_0110_enc", enc_l4, 1);
    chk("l4_0110_oh", oh_l4, 2);
    chk("l4_0110_multi", multi_l4, 1);

    step(1, 1, 5'b01000);
    chk("l4_1000_enc", enc_l4, 3);
    chk("l4_1000_multi", multi_l4, 0);
    chk("m4_1000_enc", enc_m4, 3);
    chk("m4_1000_vld", vld_m4, 1);

    for (int c = 0; c < 3; c++) begin
      step(1, 0, 5'b00001);
      chk("hold_enc", enc_m4, 3);
      chk("hold_vld", vld_m4, 1);
      chk("hold_oh", oh_m4, 8);
    end

    step(0, 1, 5'b01111);
    chk("rst2_enc", enc_m4, 0);
    chk("rst2_vld", vld_m4, 0);
    chk("rst2_oh", oh_m4, 0);
    chk("rst2_multi", multi_m4, 0);
    step(1, 1, 5'b01111);
    chk("rel_enc", enc_m4, 3);
    chk("rel_vld", vld_m4, 1);
    chk("rel_multi", multi_m4, 1);

    step(1, 1, 5'b10001);
    chk("w5_enc", enc_m5, 4);
    chk("w5_multi", multi_m5, 1);
    step(1, 1, 5'b00000);
    chk("w5_zero_vld", vld_m5, 0);
    chk("w5_zero_enc", enc_m5, 0);

    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 31) != 0);
      en    = ($urandom_range(0, 3) != 0);
      d5    = 5'($urandom);
    end
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
